conv_sequencer: RTL and testbench

- Controller that drives one computeUnit MAC through a full K×K valid convolution over an IMG_W×IMG_H feature map.
- Generates image and weight memory read addresses, plus the unit's stateC1_in, convStart and computeClear controls.
- Qualifies the unit's convResult_out with a valid strobe and an output-pixel index.
- Sits between the layer controller (start/done handshake) and the feature/weight RAMs feeding computeUnit.

---
 rtl/conv_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_conv_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sequencer.sv
// Address and control sequencer that walks one computeUnit MAC through a
// KxK valid convolution, tagging each finished window sum with its pixel index.
module conv_sequencer #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int K       = 5,
  parameter int IADDR_W = 10,
  parameter int WADDR_W = 5,
  parameter int OADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               mode_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               img_rd_o,
  output logic [IADDR_W-1:0] img_addr_o,
  output logic [WADDR_W-1:0] wt_addr_o,
  output logic               state_c1_o,
  output logic               conv_start_o,
  output logic               compute_clear_o,
  output logic               res_valid_o,
  output logic [OADDR_W-1:0] res_addr_o
);

  localparam int OW   = IMG_W - K + 1;
  localparam int OH   = IMG_H - K + 1;
  localparam int KC_W = $clog2(K);
  localparam int OX_W = (OW > 1) ? $clog2(OW) : 1;
  localparam int OY_W = (OH > 1) ? $clog2(OH) : 1;

  localparam logic [KC_W-1:0]    K_LAST  = KC_W'(K - 1);
  localparam logic [OX_W-1:0]    OX_LAST = OX_W'(OW - 1);
  localparam logic [OY_W-1:0]    OY_LAST = OY_W'(OH - 1);
  localparam logic [IADDR_W-1:0] KY_STEP = IADDR_W'(IMG_W - K + 1);
  localparam logic [IADDR_W-1:0] OY_STEP = IADDR_W'(K);
  localparam logic [1:0]         FL_EMIT = 2'd1;
  localparam logic [1:0]         FL_DONE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRIME = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_r, state_s;

  logic [KC_W-1:0]    kx_r, ky_r;
  logic [OX_W-1:0]    ox_r;
  logic [OY_W-1:0]    oy_r;
  logic [IADDR_W-1:0] win_base_r, tap_off_r;
  logic [WADDR_W-1:0] wt_cnt_r;
  logic [1:0]         fcnt_r;
  logic               last_r;
  logic               tap_clr_r, tap_res_r, clr_d1_r, res_d1_r;

  logic accept_s, issue_s, win_end_s, layer_end_s, flush_emit_s;
  logic tap_clr_s, tap_res_s;
  logic busy_s, done_s, img_rd_s, state_c1_s, conv_start_s;
  logic compute_clear_s, res_valid_s;
  logic [IADDR_W-1:0] img_addr_s;
  logic [WADDR_W-1:0] wt_addr_s;
  logic [OADDR_W-1:0] res_addr_s;

  assign accept_s     = (state_r == S_IDLE) && start_i;
  assign issue_s      = (state_r == S_PRIME) || ((state_r == S_RUN) && !last_r);
  assign win_end_s    = (kx_r == K_LAST) && (ky_r == K_LAST);
  assign layer_end_s  = win_end_s && (ox_r == OX_LAST) && (oy_r == OY_LAST);
  assign flush_emit_s = (state_r == S_FLUSH) && (fcnt_r == FL_EMIT);
  // First tap of each window reloads the accumulator; only later windows report a sum.
  assign tap_clr_s    = issue_s && (kx_r == {KC_W{1'b0}}) && (ky_r == {KC_W{1'b0}});
  assign tap_res_s    = tap_clr_s && !((ox_r == {OX_W{1'b0}}) && (oy_r == {OY_W{1'b0}}));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:  if (start_i) state_s = S_PRIME; else state_s = S_IDLE;
      S_PRIME: state_s = S_RUN;
      S_RUN:   if (last_r) state_s = S_FLUSH; else state_s = S_RUN;
      S_FLUSH: if (fcnt_r == FL_DONE) state_s = S_DONE; else state_s = S_FLUSH;
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    busy_s       = busy_o;
    conv_start_s = conv_start_o;
    done_s       = 1'b0;
    state_c1_s   = state_c1_o;
    case (state_r)
      S_IDLE: begin
        if (start_i) begin
          busy_s       = 1'b1;
          conv_start_s = 1'b1;
          state_c1_s   = mode_i;
        end else begin
          busy_s       = 1'b0;
          conv_start_s = 1'b0;
        end
      end
      S_FLUSH: begin
        if (fcnt_r == FL_DONE) begin
          busy_s       = 1'b0;
          conv_start_s = 1'b0;
          done_s       = 1'b1;
        end else begin
          busy_s       = 1'b1;
          conv_start_s = 1'b1;
        end
      end
      default: begin
        busy_s       = busy_o;
        conv_start_s = conv_start_o;
      end
    endcase

    img_rd_s = issue_s;
    if (issue_s) begin
      img_addr_s = win_base_r + tap_off_r;
      wt_addr_s  = wt_cnt_r;
    end else begin
      img_addr_s = img_addr_o;
      wt_addr_s  = wt_addr_o;
    end

    compute_clear_s = clr_d1_r | flush_emit_s;
    res_valid_s     = res_d1_r | flush_emit_s;

    if (accept_s) begin
      res_addr_s = {OADDR_W{1'b0}};
    end else if (res_valid_o) begin
      res_addr_s = res_addr_o + OADDR_W'(1);
    end else begin
      res_addr_s = res_addr_o;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      img_rd_o        <= 1'b0;
      img_addr_o      <= {IADDR_W{1'b0}};
      wt_addr_o       <= {WADDR_W{1'b0}};
      state_c1_o      <= 1'b0;
      conv_start_o    <= 1'b0;
      compute_clear_o <= 1'b0;
      res_valid_o     <= 1'b0;
      res_addr_o      <= {OADDR_W{1'b0}};
    end else begin
      busy_o          <= busy_s;
      done_o          <= done_s;
      img_rd_o        <= img_rd_s;
      img_addr_o      <= img_addr_s;
      wt_addr_o       <= wt_addr_s;
      state_c1_o      <= state_c1_s;
      conv_start_o    <= conv_start_s;
      compute_clear_o <= compute_clear_s;
      res_valid_o     <= res_valid_s;
      res_addr_o      <= res_addr_s;
    end
  end

  // Tap walker with running bases, flush timer and the two-stage clear/valid delay
  // that lines the flags up with the product leaving the multiplier register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx_r       <= {KC_W{1'b0}};
      ky_r       <= {KC_W{1'b0}};
      ox_r       <= {OX_W{1'b0}};
      oy_r       <= {OY_W{1'b0}};
      win_base_r <= {IADDR_W{1'b0}};
      tap_off_r  <= {IADDR_W{1'b0}};
      wt_cnt_r   <= {WADDR_W{1'b0}};
      last_r     <= 1'b0;
      fcnt_r     <= 2'd0;
      tap_clr_r  <= 1'b0;
      tap_res_r  <= 1'b0;
      clr_d1_r   <= 1'b0;
      res_d1_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        kx_r       <= {KC_W{1'b0}};
        ky_r       <= {KC_W{1'b0}};
        ox_r       <= {OX_W{1'b0}};
        oy_r       <= {OY_W{1'b0}};
        win_base_r <= {IADDR_W{1'b0}};
        tap_off_r  <= {IADDR_W{1'b0}};
        wt_cnt_r   <= {WADDR_W{1'b0}};
        last_r     <= 1'b0;
      end else if (issue_s) begin
        if (layer_end_s) begin
          last_r <= 1'b1;
        end
        if (win_end_s) begin
          kx_r      <= {KC_W{1'b0}};
          ky_r      <= {KC_W{1'b0}};
          tap_off_r <= {IADDR_W{1'b0}};
          wt_cnt_r  <= {WADDR_W{1'b0}};
          if (ox_r == OX_LAST) begin
            ox_r       <= {OX_W{1'b0}};
            oy_r       <= oy_r + OY_W'(1);
            win_base_r <= win_base_r + OY_STEP;
          end else begin
            ox_r       <= ox_r + OX_W'(1);
            win_base_r <= win_base_r + IADDR_W'(1);
          end
        end else if (kx_r == K_LAST) begin
          kx_r      <= {KC_W{1'b0}};
          ky_r      <= ky_r + KC_W'(1);
          tap_off_r <= tap_off_r + KY_STEP;
          wt_cnt_r  <= wt_cnt_r + WADDR_W'(1);
        end else begin
          kx_r      <= kx_r + KC_W'(1);
          tap_off_r <= tap_off_r + IADDR_W'(1);
          wt_cnt_r  <= wt_cnt_r + WADDR_W'(1);
        end
      end

      if (state_r == S_FLUSH) begin
        fcnt_r <= fcnt_r + 2'd1;
      end else begin
        fcnt_r <= 2'd0;
      end

      tap_clr_r <= tap_clr_s;
      tap_res_r <= tap_res_s;
      clr_d1_r  <= tap_clr_r;
      res_d1_r  <= tap_res_r;
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Randomised bench for conv_sequencer on a 4x4 map with a 2x2 kernel, including
// a behavioural RAM + computeUnit so window sums can be checked end to end.
module tb_conv_sequencer;

  localparam int IW = 4, IH = 4, KS = 2, IAW = 4, WAW = 2, OAW = 4;
  localparam int OW = IW - KS + 1, OH = IH - KS + 1;
  localparam int NWIN = OW * OH, KK = KS * KS;
  localparam int LAST_RD  = NWIN * KK + 1;
  localparam int DONE_REL = NWIN * KK + 5;

  logic           clk = 1'b0, rst_n = 1'b1, start_i = 1'b0, mode_i = 1'b0;
  logic           busy_o, done_o, img_rd_o, state_c1_o, conv_start_o;
  logic           compute_clear_o, res_valid_o;
  logic [IAW-1:0] img_addr_o;
  logic [WAW-1:0] wt_addr_o;
  logic [OAW-1:0] res_addr_o;

  conv_sequencer #(
    .IMG_W(IW), .IMG_H(IH), .K(KS), .IADDR_W(IAW), .WADDR_W(WAW), .OADDR_W(OAW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
    .busy_o(busy_o), .done_o(done_o), .img_rd_o(img_rd_o), .img_addr_o(img_addr_o),
    .wt_addr_o(wt_addr_o), .state_c1_o(state_c1_o), .conv_start_o(conv_start_o),
    .compute_clear_o(compute_clear_o), .res_valid_o(res_valid_o), .res_addr_o(res_addr_o)
  );

  always #5 clk = ~clk;

  int img_mem [IW*IH];
  int wt_mem  [KK];

  // RAMs (1-cycle read) and computeUnit: multiply register, conv_start edge clear, accumulator.
  int   img_q, wt_q, mult, acc;
  logic cs_d1, cs_d2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_q <= 0; wt_q <= 0; mult <= 0; acc <= 0; cs_d1 <= 1'b0; cs_d2 <= 1'b0;
    end else begin
      img_q <= img_rd_o ? img_mem[img_addr_o] : 0;
      wt_q  <= img_rd_o ? wt_mem[wt_addr_o] : 0;
      mult  <= img_q * wt_q;
      cs_d1 <= conv_start_o;
      cs_d2 <= cs_d1;
      if (cs_d1 && !cs_d2)  acc <= 0;
      else if (compute_clear_o) acc <= mult;
      else                  acc <= acc + mult;
    end
  end

  // Reference: cycles since the accepted start (-1 when idle) and the latched mode.
  int   m_rel = -1;
  logic m_mode = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rel <= -1; m_mode <= 1'b0;
    end else if (m_rel < 0) begin
      if (start_i) begin m_rel <= 1; m_mode <= mode_i; end
    end else if (m_rel >= DONE_REL) begin
      m_rel <= -1;
    end else begin
      m_rel <= m_rel + 1;
    end
  end

  function automatic int win_sum(input int w);
    int s, ox, oy;
    s = 0; ox = w % OW; oy = w / OW;
    for (int ky = 0; ky < KS; ky++)
      for (int kx = 0; kx < KS; kx++)
        s += img_mem[(oy + ky) * IW + ox + kx] * wt_mem[ky * KS + kx];
    return s;
  endfunction

  int   tests = 0, fails = 0;
  int   n_rd = 0, n_clr = 0, n_res = 0, lat = -1;
  int   cap_addr [8];
  int   cap_res  [16];
  int   lit_addr [8] = '{0, 1, 4, 5, 1, 2, 5, 6};
  logic lit_layer = 1'b0, final_req = 1'b0, final_done = 1'b0;
  int   timeouts = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Single compare process: every cycle against the reference, plus per-layer totals.
  always @(negedge clk) begin
    int r, i, w, tap;
    logic e_busy, e_done, e_rd, e_clr, e_res;
    r      = m_rel;
    e_busy = (r >= 1) && (r <= DONE_REL - 1);
    e_done = (r == DONE_REL);
    e_rd   = (r >= 2) && (r <= LAST_RD);
    e_clr  = (r >= 4) && ((r - 4) % KK == 0) && ((r - 4) / KK <= NWIN);
    e_res  = e_clr && (r >= 4 + KK);
    if (r == 1) begin n_rd = 0; n_clr = 0; n_res = 0; lat = -1; end

    chk("busy_o", int'(busy_o), int'(e_busy));
    chk("conv_start_o", int'(conv_start_o), int'(e_busy));
    chk("done_o", int'(done_o), int'(e_done));
    chk("img_rd_o", int'(img_rd_o), int'(e_rd));
    chk("compute_clear_o", int'(compute_clear_o), int'(e_clr));
    chk("res_valid_o", int'(res_valid_o), int'(e_res));
    chk("state_c1_o", int'(state_c1_o), int'(m_mode));
    if (!rst_n) begin
      chk("rst_img_addr", int'(img_addr_o), 0);
      chk("rst_wt_addr", int'(wt_addr_o), 0);
      chk("rst_res_addr", int'(res_addr_o), 0);
    end
    if (e_rd) begin
      i   = r - 2;
      w   = i / KK;
      tap = i % KK;
      chk("img_addr_o", int'(img_addr_o), ((w / OW) + tap / KS) * IW + (w % OW) + tap % KS);
      chk("wt_addr_o", int'(wt_addr_o), tap);
    end
    if (e_res) begin
      w = (r - 4) / KK - 1;
      chk("res_addr_o", int'(res_addr_o), w);
      chk("conv_result", acc, win_sum(w));
    end

    if (r >= 1) begin
      if (img_rd_o) begin
        if (n_rd < 8) cap_addr[n_rd] = int'(img_addr_o);
        n_rd++;
      end
      if (compute_clear_o) n_clr++;
      if (res_valid_o) begin
        if (n_res < 16) cap_res[n_res] = acc;
        n_res++;
      end
      if (done_o && lat < 0) lat = r;
    end

    if (r == DONE_REL) begin
      chk("layer_reads", n_rd, NWIN * KK);
      chk("layer_clears", n_clr, NWIN + 1);
      chk("layer_results", n_res, NWIN);
      if (lit_layer) begin
        for (int k = 0; k < 8; k++) chk("lit_addr", cap_addr[k], lit_addr[k]);
        chk("lit_sum_win0", cap_res[0], 10);
        chk("lit_sum_win8", cap_res[8], 50);
        chk("lit_done_latency", lat, 41);
        chk("lit_result_count", n_res, 9);
      end
    end

    if (final_req && !final_done) begin
      chk("wait_timeouts", timeouts, 0);
      final_done = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_layer(input logic mode, input int spur_at, input int rst_at);
    int c;
    bit got_done;
    start_i = 1'b1; mode_i = mode;
    tick();
    start_i = 1'b0; c = 1; got_done = 1'b0;
    while (c < 200 && !got_done) begin
      if (c == rst_at) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        return;
      end
      if (done_o) begin
        got_done = 1'b1;
      end else begin
        start_i = (c == spur_at);
        mode_i  = (c == spur_at) ? ~mode : mode;
        tick();
        c++;
      end
    end
    start_i = 1'b0;
    if (!got_done) timeouts++;
    tick();
  endtask

  task automatic fill_ones();
    for (int a = 0; a < IW * IH; a++) img_mem[a] = 1;
    for (int a = 0; a < KK; a++) wt_mem[a] = 1;
  endtask

  task automatic fill_ramp();
    for (int a = 0; a < IW * IH; a++) img_mem[a] = a;
    for (int a = 0; a < KK; a++) wt_mem[a] = 1;
  endtask

  task automatic fill_rand();
    for (int a = 0; a < IW * IH; a++) img_mem[a] = int'($urandom_range(0, 15));
    for (int a = 0; a < KK; a++) wt_mem[a] = int'($urandom_range(0, 15));
  endtask

  initial begin
    fill_ones();
    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // All-ones RAMs, mode 0: every window sums to 4.
    run_layer(1'b0, -1, -1);
    tick();

    // Ramp image, unit weights, stray start + mode flip mid-layer, then back-to-back repeat.
    fill_ramp();
    lit_layer = 1'b1;
    run_layer(1'b1, 10, -1);
    run_layer(1'b1, 10, -1);
    tick();

    // Reset in the middle of RUN, then a clean restart.
    run_layer(1'b1, -1, 20);
    run_layer(1'b0, -1, -1);
    lit_layer = 1'b0;

    for (int it = 0; it < 6; it++) begin
      int spur, rst_at, gap;
      fill_rand();
      spur   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 38)) : -1;
      rst_at = (it == 3) ? int'($urandom_range(3, 38)) : -1;
      run_layer(1'($urandom_range(0, 1)), spur, rst_at);
      gap = int'($urandom_range(0, 3));
      repeat (gap) tick();
    end
    run_layer(1'b0, -1, -1);

    final_req = 1'b1;
    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
